// File: rtl/issue_unit_pkg.sv
// rtl/issue_unit_pkg.sv - opcode constants and default ROB tag width for the issue stage
package issue_unit_pkg;

    localparam int ROB_BIT_DEFAULT = 3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/issue_decoder.sv
// rtl/issue_decoder.sv - combinational class/immediate decode of the held instruction
module issue_decoder
    import issue_unit_pkg::*;
(
    input  logic [31:0] inst,
    output logic        target_lsb,
    output logic        writes_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        imm_op2,
    output logic        pc_op1,
    output logic [31:0] imm
);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'd0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        target_lsb = 1'b0;
        writes_rd  = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        imm_op2    = 1'b0;
        pc_op1     = 1'b0;
        imm        = 32'd0;
        case (inst[6:0])
            OPC_LOAD: begin
                target_lsb = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b1; imm_op2 = 1'b1; imm = i_imm;
            end
            OPC_STORE: begin
                target_lsb = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = s_imm;
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1; uses_rs1 = 1'b1; imm_op2 = 1'b1; imm = i_imm;
            end
            OPC_OP: begin
                writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1; pc_op1 = 1'b1; imm_op2 = 1'b1; imm = u_imm;
            end
            OPC_JAL: begin
                writes_rd = 1'b1; pc_op1 = 1'b1; imm_op2 = 1'b1; imm = j_imm;
            end
            OPC_JALR: begin
                writes_rd = 1'b1; uses_rs1 = 1'b1; imm_op2 = 1'b1; imm = i_imm;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = b_imm;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - in-order issue stage with rename table; ISSUE_STAT_EN adds issue/stall counters
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int ROB_BIT = ROB_BIT_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               inst_valid,
    input  logic [31:0]        inst_in,
    input  logic [31:0]        inst_addr_in,
    output logic               inst_ready,
    input  logic               rob_full,
    input  logic               rs_full,
    input  logic               lsb_full,
    input  logic [ROB_BIT-1:0] rob_tail,
    output logic [ROB_BIT-1:0] rob_q1_entry,
    output logic [ROB_BIT-1:0] rob_q2_entry,
    input  logic               rob_q1_ready,
    input  logic               rob_q2_ready,
    input  logic [31:0]        rob_q1_value,
    input  logic [31:0]        rob_q2_value,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    input  logic               commit_valid,
    input  logic [4:0]         commit_rd,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    output logic               rob_issue,
    output logic               rs_issue,
    output logic               lsb_issue,
    output logic [6:0]         op_type_out,
    output logic [2:0]         op_out,
    output logic [31:0]        reg1_v,
    output logic [31:0]        reg2_v,
    output logic               has_dep1,
    output logic               has_dep2,
    output logic [ROB_BIT-1:0] rob_entry1,
    output logic [ROB_BIT-1:0] rob_entry2,
    output logic [ROB_BIT-1:0] rd_rob,
`ifdef ISSUE_STAT_EN
    output logic [31:0]        issue_count,
    output logic [31:0]        stall_count,
`endif
    output logic [31:0]        inst_out,
    output logic [31:0]        inst_addr_out
);

    logic               hold_valid;
    logic [31:0]        hold_inst;
    logic [31:0]        hold_pc;
    logic [31:0]        regfile [0:31];
    logic [31:0]        busy;
    logic [ROB_BIT-1:0] tags [0:31];

    logic        target_lsb, writes_rd, uses_rs1, uses_rs2, imm_op2, pc_op1;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        fire;
    logic [32:0] res1, res2;

    issue_decoder u_decoder (
        .inst       (hold_inst),
        .target_lsb (target_lsb),
        .writes_rd  (writes_rd),
        .uses_rs1   (uses_rs1),
        .uses_rs2   (uses_rs2),
        .imm_op2    (imm_op2),
        .pc_op1     (pc_op1),
        .imm        (imm)
    );

    assign rs1 = hold_inst[19:15];
    assign rs2 = hold_inst[24:20];
    assign rd  = hold_inst[11:7];

    assign fire = rdy_in && hold_valid && !rob_full && !rob_clear_up
                  && !(target_lsb ? lsb_full : rs_full);
    assign inst_ready = rdy_in && !rob_clear_up && (!hold_valid || fire);

    assign rob_issue = fire;
    assign rs_issue  = fire && !target_lsb;
    assign lsb_issue = fire && target_lsb;

    assign rob_q1_entry = tags[rs1];
    assign rob_q2_entry = tags[rs2];

    // Returns {pending, value}; the value bits are 0 while still pending.
    function automatic logic [32:0] resolve(input logic [4:0] r, input logic q_ready,
                                            input logic [31:0] q_value);
        logic [32:0] res;
        if (r == 5'd0)
            res = {1'b0, 32'd0};
        else if (!busy[r])
            res = {1'b0, (commit_valid && commit_rd == r) ? commit_value : regfile[r]};
        else if (rs_ready && rs_rob_entry == tags[r])
            res = {1'b0, rs_value};
        else if (lsb_ready && lsb_rob_entry == tags[r])
            res = {1'b0, lsb_value};
        else if (q_ready)
            res = {1'b0, q_value};
        else
            res = {1'b1, 32'd0};
        return res;
    endfunction

    assign res1 = resolve(rs1, rob_q1_ready, rob_q1_value);
    assign res2 = resolve(rs2, rob_q2_ready, rob_q2_value);

    always_comb begin
        op_type_out   = 7'd0;
        op_out        = 3'd0;
        reg1_v        = 32'd0;
        reg2_v        = 32'd0;
        has_dep1      = 1'b0;
        has_dep2      = 1'b0;
        rob_entry1    = '0;
        rob_entry2    = '0;
        rd_rob        = '0;
        inst_out      = 32'd0;
        inst_addr_out = 32'd0;
        if (hold_valid) begin
            op_type_out   = hold_inst[6:0];
            op_out        = hold_inst[14:12];
            inst_out      = hold_inst;
            inst_addr_out = hold_pc;
            rd_rob        = rob_tail;
            if (pc_op1) begin
                reg1_v = hold_pc;
            end else if (uses_rs1) begin
                {has_dep1, reg1_v} = res1;
                if (res1[32]) rob_entry1 = tags[rs1];
            end
            if (imm_op2) begin
                reg2_v = imm;
            end else if (uses_rs2) begin
                {has_dep2, reg2_v} = res2;
                if (res2[32]) rob_entry2 = tags[rs2];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_valid <= 1'b0;
            hold_inst  <= 32'd0;
            hold_pc    <= 32'd0;
            busy       <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= 32'd0;
                tags[i]    <= '0;
            end
        end else if (rdy_in) begin
            // Committed values land even during a flush.
            if (commit_valid && commit_rd != 5'd0)
                regfile[commit_rd] <= commit_value;
            if (rob_clear_up) begin
                hold_valid <= 1'b0;
                busy       <= 32'd0;
            end else begin
                if (inst_valid && inst_ready) begin
                    hold_valid <= 1'b1;
                    hold_inst  <= inst_in;
                    hold_pc    <= inst_addr_in;
                end else if (fire) begin
                    hold_valid <= 1'b0;
                end
                if (commit_valid && commit_rd != 5'd0 && tags[commit_rd] == commit_rob_entry)
                    busy[commit_rd] <= 1'b0;
                // Placed after the commit clear so a same-cycle rename of that rd wins.
                if (fire && writes_rd && rd != 5'd0) begin
                    busy[rd] <= 1'b1;
                    tags[rd] <= rob_tail;
                end
            end
        end
    end

`ifdef ISSUE_STAT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            issue_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (fire)
                issue_count <= issue_count + 32'd1;
            if (hold_valid && !fire && rdy_in)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - scoreboard and table-driven bench for issue_unit
module tb_issue_unit;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = 32'd0, pc = 32'd0;
    logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
    logic [2:0]  rob_tail = 3'd0;
    logic        q1_ready = 1'b0, q2_ready = 1'b0;
    logic [31:0] q1_value = 32'd0, q2_value = 32'd0;
    logic        rs_ready = 1'b0, lsb_ready = 1'b0;
    logic [2:0]  rs_rob_entry = 3'd0, lsb_rob_entry = 3'd0;
    logic [31:0] rs_value = 32'd0, lsb_value = 32'd0;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_rd = 5'd0;
    logic [2:0]  commit_rob_entry = 3'd0;
    logic [31:0] commit_value = 32'd0;

    logic        inst_ready, rob_issue, rs_issue, lsb_issue, has_dep1, has_dep2;
    logic [2:0]  q1_entry, q2_entry, rob_entry1, rob_entry2, rd_rob, op_out;
    logic [6:0]  op_type_out;
    logic [31:0] reg1_v, reg2_v, inst_out, inst_addr_out;
`ifdef ISSUE_STAT_EN
    logic [31:0] issue_count, stall_count;
    logic [31:0] s0;
`endif

    issue_unit #(.ROB_BIT(3)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_clear_up(clear),
        .inst_valid(inst_valid), .inst_in(inst), .inst_addr_in(pc), .inst_ready(inst_ready),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tail(rob_tail),
        .rob_q1_entry(q1_entry), .rob_q2_entry(q2_entry),
        .rob_q1_ready(q1_ready), .rob_q2_ready(q2_ready),
        .rob_q1_value(q1_value), .rob_q2_value(q2_value),
        .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
        .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
        .op_type_out(op_type_out), .op_out(op_out), .reg1_v(reg1_v), .reg2_v(reg2_v),
        .has_dep1(has_dep1), .has_dep2(has_dep2),
        .rob_entry1(rob_entry1), .rob_entry2(rob_entry2), .rd_rob(rd_rob),
`ifdef ISSUE_STAT_EN
        .issue_count(issue_count), .stall_count(stall_count),
`endif
        .inst_out(inst_out), .inst_addr_out(inst_addr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lsb;
        logic [31:0] r1, r2;
        logic        d1, d2;
        logic [2:0]  e1, e2, rdr;
        logic [6:0]  opc;
    } exp_t;

    typedef struct {
        logic [31:0] inst, pc;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   checks = 0, errors = 0, issued = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic lsb, input logic [31:0] r1, input logic [31:0] r2,
                                input logic d1, input logic d2, input logic [2:0] e1,
                                input logic [2:0] e2, input logic [2:0] rdr, input logic [6:0] opc);
        exp_t e;
        e.lsb = lsb; e.r1 = r1; e.r2 = r2; e.d1 = d1; e.d2 = d2;
        e.e1 = e1; e.e2 = e2; e.rdr = rdr; e.opc = opc;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (rob_issue) begin
                issued++;
                if (sb.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rs_issue", {31'd0, rs_issue}, {31'd0, !e.lsb});
                    chk("lsb_issue", {31'd0, lsb_issue}, {31'd0, e.lsb});
                    chk("has_dep1", {31'd0, has_dep1}, {31'd0, e.d1});
                    chk("has_dep2", {31'd0, has_dep2}, {31'd0, e.d2});
                    if (e.d1) chk("rob_entry1", {29'd0, rob_entry1}, {29'd0, e.e1});
                    else      chk("reg1_v", reg1_v, e.r1);
                    if (e.d2) chk("rob_entry2", {29'd0, rob_entry2}, {29'd0, e.e2});
                    else      chk("reg2_v", reg2_v, e.r2);
                    chk("rd_rob", {29'd0, rd_rob}, {29'd0, e.rdr});
                    chk("op_type", {25'd0, op_type_out}, {25'd0, e.opc});
                end
            end else if (rs_issue || lsb_issue) begin
                chk("strobe_without_rob_issue", 32'd1, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p);
        bit ok;
        ok = 1'b0;
        inst_valid = 1'b1;
        inst = i;
        pc = p;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (inst_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, n0;
        tbl[0] = '{32'h123452B7, 32'h200, mk(0, 32'h200, 32'h12345000, 0, 0, 0, 0, 7, 7'h37)};
        tbl[1] = '{32'h008000EF, 32'h204, mk(0, 32'h204, 32'd8, 0, 0, 0, 0, 7, 7'h6F)};
        tbl[2] = '{32'h00000063, 32'h208, mk(0, 32'd0, 32'd0, 0, 0, 0, 0, 7, 7'h63)};
        tbl[3] = '{32'hFFF00213, 32'h20C, mk(0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 7, 7'h13)};
        tbl[4] = '{32'h00802183, 32'h210, mk(1, 32'd0, 32'd8, 0, 0, 0, 0, 7, 7'h03)};
        tbl[5] = '{32'h00002223, 32'h214, mk(1, 32'd0, 32'd0, 0, 0, 0, 0, 7, 7'h23)};
        tbl[6] = '{32'h00001397, 32'h220, mk(0, 32'h220, 32'h1000, 0, 0, 0, 0, 7, 7'h17)};
        tbl[7] = '{32'h01000067, 32'h224, mk(0, 32'd0, 32'd16, 0, 0, 0, 0, 7, 7'h67)};

        #22 rst = 1'b0;
        @(negedge clk);
        chk("reset_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("reset_strobes", {29'd0, rob_issue, rs_issue, lsb_issue}, 32'd0);
        chk("reset_reg1_v", reg1_v, 32'd0);
        chk("reset_outputs", {22'd0, has_dep1, has_dep2, rd_rob, op_type_out}, 32'd0);
        tick();

        // addi x1,x0,5 renames x1 to tag 2
        rob_tail = 3'd2;
        sb.push_back(mk(0, 32'd0, 32'd5, 0, 0, 0, 0, 2, 7'h13));
        send(32'h00500093, 32'h100);
        tick();

        // add x2,x1,x1 with x1 pending
        rob_tail = 3'd3;
        sb.push_back(mk(0, 32'd0, 32'd0, 1, 1, 2, 2, 3, 7'h33));
        send(32'h00108133, 32'h104);
        tick();

        // same add, producer broadcast on the ALU CDB in the issue cycle
        rob_tail = 3'd4;
        sb.push_back(mk(0, 32'd5, 32'd5, 0, 0, 0, 0, 4, 7'h33));
        send(32'h00108133, 32'h108);
        rs_ready = 1'b1; rs_rob_entry = 3'd2; rs_value = 32'd5;
        tick();
        rs_ready = 1'b0;

        // lw stalled by lsb_full for three cycles
        rob_tail = 3'd5;
        lsb_full = 1'b1;
        sb.push_back(mk(1, 32'd0, 32'd8, 0, 0, 0, 0, 5, 7'h03));
        send(32'h00802183, 32'h10C);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lw_stall_lsb_issue", {31'd0, lsb_issue}, 32'd0);
            chk("lw_stall_inst_ready", {31'd0, inst_ready}, 32'd0);
            chk("lw_stall_reg2_v", reg2_v, 32'd8);
            tick();
        end
        lsb_full = 1'b0;
        tick();
        drain("lw_issued");

        // addi x1,x0,7 renames x1 to tag 4 while tag 2 commits x1=5
        rob_tail = 3'd4;
        sb.push_back(mk(0, 32'd0, 32'd7, 0, 0, 0, 0, 4, 7'h13));
        send(32'h00700093, 32'h110);
        commit_valid = 1'b1; commit_rd = 5'd1; commit_rob_entry = 3'd2; commit_value = 32'd5;
        tick();
        commit_valid = 1'b0;

        rob_tail = 3'd6;
        sb.push_back(mk(0, 32'd0, 32'd0, 1, 1, 4, 4, 6, 7'h33));
        send(32'h00108133, 32'h114);
        @(negedge clk);
        chk("q1_tag_after_rename", {29'd0, q1_entry}, 32'd4);
        tick();

        // sw stalled by rob_full, then flushed
        rob_full = 1'b1;
        send(32'h00102223, 32'h118);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
`ifdef ISSUE_STAT_EN
            if (k == 0) s0 = stall_count;
`endif
            chk("sw_stall_no_strobe", {30'd0, rob_issue, lsb_issue}, 32'd0);
            tick();
        end
`ifdef ISSUE_STAT_EN
        @(negedge clk);
        chk("stall_count_delta", stall_count - s0, 32'd2);
        tick();
`endif
        clear = 1'b1;
        @(negedge clk);
        chk("flush_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("flush_no_strobe", {31'd0, rob_issue}, 32'd0);
        tick();
        clear = 1'b0;
        rob_full = 1'b0;
        @(negedge clk);
        chk("post_flush_no_strobe", {29'd0, rob_issue, rs_issue, lsb_issue}, 32'd0);
        chk("post_flush_op_type", {25'd0, op_type_out}, 32'd0);
        tick();
        drain("flush_dropped_sw");

        rob_tail = 3'd1;
        sb.push_back(mk(0, 32'd5, 32'd5, 0, 0, 0, 0, 1, 7'h33));
        send(32'h00108133, 32'h120);
        tick();
        sb.push_back(mk(0, 32'd0, 32'd0, 0, 0, 0, 0, 1, 7'h33));
        send(32'h00018333, 32'h124);
        tick();
        drain("post_flush_reads");

        // back-to-back table: one instruction per cycle
        rob_tail = 3'd7;
        n0 = issued;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(tbl[i].e);
            send(tbl[i].inst, tbl[i].pc);
        end
        tick();
        chk("table_issue_count", issued - n0, 32'd8);
        chk("table_cycles", cyc - c0, 32'd9);
        drain("table_drained");

        // rdy_in low freezes a held instruction
        rob_tail = 3'd0;
        sb.push_back(mk(0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 7'h13));
        send(32'hFFF00213, 32'h300);
        rdy = 1'b0;
        @(negedge clk);
        chk("rdy_low_no_strobe", {31'd0, rob_issue}, 32'd0);
        chk("rdy_low_inst_ready", {31'd0, inst_ready}, 32'd0);
        tick();
        rdy = 1'b1;
        tick();
        drain("rdy_resume");

`ifdef ISSUE_STAT_EN
        @(negedge clk);
        chk("issue_count", issue_count, issued);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
